// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: write-back arbiter for the integer register file's single
// write port. Two producers (ALU and LSU) compete over valid/ready
// handshakes. The LSU normally wins, but a starvation counter forces an ALU
// grant after STARVE_LIMIT consecutive lost cycles. The winning request is
// captured into a registered output stage that drives the register file.
// The register file never back-pressures, so there is no buffering.

module rf_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int RFIDX_WIDTH  = 5,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [RFIDX_WIDTH-1:0] alu_addr,
    input  logic [XLEN-1:0]        alu_data,

    input  logic                   lsu_valid,
    output logic                   lsu_ready,
    input  logic [RFIDX_WIDTH-1:0] lsu_addr,
    input  logic [XLEN-1:0]        lsu_data,

    output logic                   reg_write,
    output logic [RFIDX_WIDTH-1:0] write_addr,
    output logic [XLEN-1:0]        write_data,
    output logic                   wb_src
);

    // The counter is 4 bits wide, so the limit is compared in that width.
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Source encoding for wb_src.
    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSU = 1'b1;

    logic [3:0] starve_cnt;
    logic       force_alu;
    logic       alu_xfer;
    logic       lsu_xfer;

    // Grant decision: LSU first unless the ALU has been starved long enough;
    // nothing is granted while reset is held so pending requests survive it.
    always_comb begin
        force_alu = (starve_cnt >= LIMIT);
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (!rst) begin
            lsu_ready = lsu_valid && !(alu_valid && force_alu);
            alu_ready = alu_valid && (!lsu_valid || force_alu);
        end
        alu_xfer = alu_valid && alu_ready;
        lsu_xfer = lsu_valid && lsu_ready;
    end

    // Count consecutive cycles the ALU waited; clear once it wins or goes idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (alu_valid && !alu_ready) begin
            if (starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else begin
            starve_cnt <= 4'd0;
        end
    end

    // Registered write port: capture the granted request; x0 writes finish
    // the handshake but never raise reg_write. Idle cycles hold addr/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write  <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            wb_src     <= SRC_ALU;
        end else if (alu_xfer) begin
            reg_write  <= (alu_addr != '0);
            write_addr <= alu_addr;
            write_data <= alu_data;
            wb_src     <= SRC_ALU;
        end else if (lsu_xfer) begin
            reg_write  <= (lsu_addr != '0);
            write_addr <= lsu_addr;
            write_data <= lsu_data;
            wb_src     <= SRC_LSU;
        end else begin
            reg_write  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios with
// hand-computed expectations, one task per scenario.

module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_addr;
    logic [31:0] lsu_data;
    logic        reg_write;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        wb_src;

    int errors = 0;
    int checks = 0;

    logic [31:0] rf [0:31];

    rf_wb_arbiter #(
        .XLEN(32),
        .RFIDX_WIDTH(5),
        .STARVE_LIMIT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .alu_valid(alu_valid),
        .alu_ready(alu_ready),
        .alu_addr(alu_addr),
        .alu_data(alu_data),
        .lsu_valid(lsu_valid),
        .lsu_ready(lsu_ready),
        .lsu_addr(lsu_addr),
        .lsu_data(lsu_data),
        .reg_write(reg_write),
        .write_addr(write_addr),
        .write_data(write_data),
        .wb_src(wb_src)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model committing whatever the arbiter drives.
    always @(posedge clk) begin
        if (reg_write) rf[write_addr] <= write_data;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational readies settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h33;
        lsu_valid = 1'b1; lsu_addr = 5'd4; lsu_data = 32'h44;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (alu_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_alu_ready cyc%0d: got %b want 0", i, alu_ready); end
            checks++; if (lsu_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_lsu_ready cyc%0d: got %b want 0", i, lsu_ready); end
        end
        checks++; if (reg_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_reg_write: got %b want 0", reg_write); end
        checks++; if (write_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_write_addr: got %0d want 0", write_addr); end
        checks++; if (write_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_write_data: got %h want 0", write_data); end
        checks++; if (wb_src !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_src: got %b want 0", wb_src); end
        rst = 1'b0;
        settle();
        checks++; if (lsu_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_lsu_ready: got %b want 1", lsu_ready); end
        checks++; if (alu_ready !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_alu_ready: got %b want 0", alu_ready); end
        tick();
        lsu_valid = 1'b0;
        checks++; if (write_addr !== 5'd4 || write_data !== 32'h44 || wb_src !== 1'b1 || reg_write !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_lsu_write: got we=%b a=%0d d=%h s=%b want we=1 a=4 d=44 s=1", reg_write, write_addr, write_data, wb_src); end
        settle();
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_alu_pending: got %b want 1", alu_ready); end
        tick();
        alu_valid = 1'b0;
        checks++; if (write_addr !== 5'd3 || write_data !== 32'h33 || wb_src !== 1'b0 || reg_write !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_alu_write: got we=%b a=%0d d=%h s=%b want we=1 a=3 d=33 s=0", reg_write, write_addr, write_data, wb_src); end
        tick();
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        lsu_valid = 1'b0;
        settle();
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_alu_ready: got %b want 1", alu_ready); end
        checks++; if (lsu_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_lsu_ready: got %b want 0", lsu_ready); end
        tick();
        alu_valid = 1'b0;
        checks++; if (reg_write !== 1'b1) begin errors++; $display("[TB] FAIL single_reg_write: got %b want 1", reg_write); end
        checks++; if (write_addr !== 5'd5) begin errors++; $display("[TB] FAIL single_write_addr: got %0d want 5", write_addr); end
        checks++; if (write_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_write_data: got %h want deadbeef", write_data); end
        checks++; if (wb_src !== 1'b0) begin errors++; $display("[TB] FAIL single_wb_src: got %b want 0", wb_src); end
        tick();
        checks++; if (reg_write !== 1'b0) begin errors++; $display("[TB] FAIL idle_reg_write: got %b want 0", reg_write); end
        checks++; if (write_addr !== 5'd5 || write_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL idle_hold: got a=%0d d=%h want a=5 d=deadbeef", write_addr, write_data); end
    endtask

    task automatic test_x0_suppression();
        lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'h12345678;
        settle();
        checks++; if (lsu_ready !== 1'b1) begin errors++; $display("[TB] FAIL x0_lsu_ready: got %b want 1", lsu_ready); end
        tick();
        lsu_valid = 1'b0;
        checks++; if (reg_write !== 1'b0) begin errors++; $display("[TB] FAIL x0_reg_write: got %b want 0", reg_write); end
        checks++; if (write_addr !== 5'd0 || write_data !== 32'h12345678 || wb_src !== 1'b1) begin errors++; $display("[TB] FAIL x0_capture: got a=%0d d=%h s=%b want a=0 d=12345678 s=1", write_addr, write_data, wb_src); end
        tick();
    endtask

    task automatic test_starvation();
        // Grant pattern and counter value seen before each cycle's edge.
        logic       exp_alu [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] exp_cnt [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd0};
        logic [4:0] next_lsu = 5'd2;
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_addr = next_lsu; lsu_data = 32'h100 + 32'(next_lsu);
        for (int i = 0; i < 6; i++) begin
            settle();
            checks++; if (alu_ready !== exp_alu[i] || lsu_ready !== !exp_alu[i]) begin errors++; $display("[TB] FAIL starve_grant cyc%0d: got alu=%b lsu=%b want alu=%b lsu=%b", i, alu_ready, lsu_ready, exp_alu[i], !exp_alu[i]); end
            checks++; if (dut.starve_cnt !== exp_cnt[i]) begin errors++; $display("[TB] FAIL starve_cnt cyc%0d: got %0d want %0d", i, dut.starve_cnt, exp_cnt[i]); end
            tick();
            if (exp_alu[i]) begin
                checks++; if (reg_write !== 1'b1 || write_addr !== 5'd1 || write_data !== 32'h11 || wb_src !== 1'b0) begin errors++; $display("[TB] FAIL starve_alu_write cyc%0d: got we=%b a=%0d d=%h s=%b want we=1 a=1 d=11 s=0", i, reg_write, write_addr, write_data, wb_src); end
                alu_valid = 1'b0;
            end else begin
                checks++; if (reg_write !== 1'b1 || write_addr !== next_lsu || write_data !== 32'h100 + 32'(next_lsu) || wb_src !== 1'b1) begin errors++; $display("[TB] FAIL starve_lsu_write cyc%0d: got we=%b a=%0d d=%h s=%b want we=1 a=%0d s=1", i, reg_write, write_addr, write_data, wb_src, next_lsu); end
                next_lsu = next_lsu + 5'd1;
                lsu_addr = next_lsu; lsu_data = 32'h100 + 32'(next_lsu);
            end
        end
        checks++; if (next_lsu !== 5'd7) begin errors++; $display("[TB] FAIL starve_lsu_count: got next=%0d want 7", next_lsu); end
        lsu_valid = 1'b0;
        tick();
    endtask

    task automatic test_same_dest();
        rf[7] = 32'h0;
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'hA;
        lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'hB;
        settle();
        checks++; if (lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin errors++; $display("[TB] FAIL race_first_grant: got alu=%b lsu=%b want alu=0 lsu=1", alu_ready, lsu_ready); end
        tick();
        lsu_valid = 1'b0;
        checks++; if (reg_write !== 1'b1 || write_addr !== 5'd7 || write_data !== 32'hB || wb_src !== 1'b1) begin errors++; $display("[TB] FAIL race_lsu_write: got we=%b a=%0d d=%h s=%b want we=1 a=7 d=b s=1", reg_write, write_addr, write_data, wb_src); end
        tick();
        alu_valid = 1'b0;
        checks++; if (reg_write !== 1'b1 || write_addr !== 5'd7 || write_data !== 32'hA || wb_src !== 1'b0) begin errors++; $display("[TB] FAIL race_alu_write: got we=%b a=%0d d=%h s=%b want we=1 a=7 d=a s=0", reg_write, write_addr, write_data, wb_src); end
        tick();
        checks++; if (rf[7] !== 32'hA) begin errors++; $display("[TB] FAIL race_rf_x7: got %h want a", rf[7]); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [4:0] next_lsu = 5'd9;
        alu_valid = 1'b1; alu_addr = 5'd8; alu_data = 32'h80;
        lsu_valid = 1'b1; lsu_addr = next_lsu; lsu_data = 32'h200 + 32'(next_lsu);
        for (int i = 0; i < 2; i++) begin
            tick();
            next_lsu = next_lsu + 5'd1;
            lsu_addr = next_lsu; lsu_data = 32'h200 + 32'(next_lsu);
        end
        rst = 1'b1;
        settle();
        checks++; if (dut.starve_cnt !== 4'd2) begin errors++; $display("[TB] FAIL mid_cnt_before: got %0d want 2", dut.starve_cnt); end
        checks++; if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ready: got alu=%b lsu=%b want 0 0", alu_ready, lsu_ready); end
        tick();
        rst = 1'b0;
        checks++; if (dut.starve_cnt !== 4'd0) begin errors++; $display("[TB] FAIL mid_cnt_after: got %0d want 0", dut.starve_cnt); end
        checks++; if (reg_write !== 1'b0) begin errors++; $display("[TB] FAIL mid_reg_write: got %b want 0", reg_write); end
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (alu_ready !== (i == 3) || lsu_ready !== (i != 3)) begin errors++; $display("[TB] FAIL mid_grant cyc%0d: got alu=%b lsu=%b want alu=%b", i, alu_ready, lsu_ready, (i == 3)); end
            tick();
            if (i == 3) begin
                checks++; if (write_addr !== 5'd8 || wb_src !== 1'b0) begin errors++; $display("[TB] FAIL mid_alu_write: got a=%0d s=%b want a=8 s=0", write_addr, wb_src); end
                alu_valid = 1'b0;
            end else begin
                checks++; if (write_addr !== next_lsu || wb_src !== 1'b1) begin errors++; $display("[TB] FAIL mid_lsu_write cyc%0d: got a=%0d s=%b want a=%0d s=1", i, write_addr, wb_src, next_lsu); end
                next_lsu = next_lsu + 5'd1;
                lsu_addr = next_lsu; lsu_data = 32'h200 + 32'(next_lsu);
            end
        end
        lsu_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        test_reset();
        test_single_alu();
        test_x0_suppression();
        test_starvation();
        test_same_dest();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
